da_fir_mac: RTL

Parametrised distributed-arithmetic FIR multiply-accumulate engine. It is the generalised successor of the fixed 8-tap, 8-bit `distr_arith` datapath. It accepts one packed vector of `NTAPS` samples and processes them bit-serially, MSB first, over `XW` cycles to produce `y = Σ c_k·x_k`. Coefficients are runtime-writable and signed/unsigned sample mode is selectable. It sits between the sample delay line and the output stage of the FIR, with valid/ready handshakes on both sides.

---
 rtl/da_fir_mac.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/da_fir_mac.sv
// da_fir_mac
// Distributed-arithmetic FIR multiply-accumulate engine. One packed vector of
// NTAPS samples is accepted, then processed bit-serially (MSB first) over XW
// cycles to produce y = sum(c_k * x_k). Coefficients are runtime-writable.
//
// Ports:
//   clk3       - clock, rising edge
//   reset      - synchronous active-high reset
//   x_in       - packed samples, tap k at [k*XW +: XW]
//   in_valid   - x_in valid
//   in_ready   - engine can accept a vector
//   coef_we    - coefficient write strobe
//   coef_addr  - tap index for the write (ignored if >= NTAPS)
//   coef_data  - signed coefficient value
//   y          - two's complement result (accumulator register)
//   out_valid  - y valid
//   out_ready  - downstream accepts y
//   busy       - high while the bit-serial run is in progress
module da_fir_mac #(
  parameter int                  NTAPS     = 8,
  parameter int                  XW        = 8,
  parameter int                  CW        = 8,
  parameter int                  ACCW      = 32,
  parameter bit                  SIGNED_X  = 1'b1,
  parameter logic [NTAPS*CW-1:0] COEF_INIT = {8'd8, 8'd7, 8'd6, 8'd5,
                                              8'd4, 8'd3, 8'd2, 8'd1}
) (
  input  logic                                   clk3,
  input  logic                                   reset,
  input  logic [NTAPS*XW-1:0]                    x_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   coef_we,
  input  logic [((NTAPS > 1) ? $clog2(NTAPS) : 1)-1:0] coef_addr,
  input  logic [CW-1:0]                          coef_data,
  output logic [ACCW-1:0]                        y,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int              AW       = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int              CNTW     = $clog2(XW);
  localparam logic [AW:0]     NTAPS_L  = (AW+1)'(NTAPS);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(XW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]   coef  [NTAPS];
  logic [CW-1:0]   wcoef [NTAPS];
  logic [XW-1:0]   xs    [NTAPS];
  logic [CNTW-1:0] cnt;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] term;
  logic            accept;

  assign accept = in_valid && in_ready;
  assign y      = acc;

  // State register
  always_ff @(posedge clk3) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? S_RUN : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // DA term: sum of working coefficients masked by the current sample bit,
  // each sign-extended to the accumulator width.
  always_comb begin
    term = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      if (xs[k][XW-1]) begin
        term = term + {{(ACCW-CW){wcoef[k][CW-1]}}, wcoef[k]};
      end
    end
  end

  // Coefficient bank, snapshot, sample shift register and accumulator
  always_ff @(posedge clk3) begin
    if (reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        coef[k]  <= COEF_INIT[k*CW +: CW];
        wcoef[k] <= '0;
        xs[k]    <= '0;
      end
      cnt <= '0;
      acc <= '0;
    end else begin
      if (coef_we && ({1'b0, coef_addr} < NTAPS_L)) begin
        coef[coef_addr] <= coef_data;
      end

      if (accept) begin
        // Non-blocking read of coef gives the pre-write value on a
        // same-cycle write.
        for (int unsigned k = 0; k < NTAPS; k++) begin
          xs[k]    <= x_in[k*XW +: XW];
          wcoef[k] <= coef[k];
        end
        cnt <= '0;
      end else if (state == S_RUN) begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
          xs[k] <= {xs[k][XW-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        // MSB carries negative weight for two's complement samples.
        if (cnt == '0) begin
          acc <= SIGNED_X ? ('0 - term) : term;
        end else begin
          acc <= {acc[ACCW-2:0], 1'b0} + term;
        end
      end
    end
  end

endmodule
